mem_issue_sequencer: RTL
========================

MEM_ISSUE_SEQUENCER -- requirements
Module: mem_issue_sequencer

Interface
REQ-001 SHALL have parameter LOAD_OP, default 4'b0010, opcode treated as a load.
REQ-002 SHALL have parameter STORE_OP, default 4'b0100, opcode treated as a store.
REQ-003 SHALL have parameter CNT_W, default 8, width of the stall counter.
REQ-004 SHALL use one clock and an asynchronous, active-low reset.
REQ-005 SHALL have port: clk  input  1  single clock, rising-edge.
REQ-006 SHALL have port: rst_n  input  1  asynchronous active-low reset.
REQ-007 SHALL have port: grp_valid  input  1  a 4-instruction group is offered.
REQ-008 SHALL have port: grp_ready  output  1  block accepts the offered group this cycle.
REQ-009 SHALL have ports: op1..op4  input  4 each  opcodes of slots 1..4.
REQ-010 SHALL have port: vld  input  4  per-slot history-valid; bit i-1 is slot i.
REQ-011 SHALL have port: mem_ready  input  1  the single memory port (ALU4) can take an op.
REQ-012 SHALL have port: issue  output  4  one-cycle issue strobe per slot.
REQ-013 SHALL have port: mem_issue  output  1  a memory op is issued this cycle.
REQ-014 SHALL have port: mem_slot  output  2  index (0..3 = slot 1..4) of the issued memory op, routed to ALU4.
REQ-015 SHALL have port: busy  output  1  the group still has pending slots.
REQ-016 SHALL have port: stall_cnt  output  CNT_W  saturating count of memory-stall cycles.

Function
REQ-017 SHALL have FSM states: IDLE and ISSUE.
REQ-018 SHALL define a slot as memory when its opcode equals LOAD_OP or STORE_OP.
REQ-019 SHALL drive grp_ready =1 in IDLE, and =1 in ISSUE only when this cycle's issue clears every pending bit; otherwise =0.
REQ-020 On grp_valid && grp_ready, SHALL register op1..op4 and set pending = vld.
REQ-021 SHALL then go to ISSUE if vld != 0, else stay in or return to IDLE.
REQ-022 SHALL make the first issue of an accepted group visible in the cycle after acceptance (latency 1).
REQ-023 In ISSUE, SHALL let k be the lowest-index pending memory slot and m the second-lowest.
REQ-024 Issue rule, no pending memory slot: issue all pending slots.
REQ-025 Issue rule, mem_ready=1: issue all pending slots with index < m, or all pending slots if no m exists.
REQ-026 Issue rule, mem_ready=0 with k existing: issue only pending slots with index < k.
REQ-027 SHALL therefore issue at most one memory op per cycle, and never issue a slot ahead of an older pending memory op.
REQ-028 SHALL make issue, mem_issue and mem_slot combinational from the registered state plus mem_ready; mem_issue=1 iff slot k is issued, with mem_slot = k; otherwise mem_slot = 0.
REQ-029 SHALL clear the issued pending bits at the clock edge.
REQ-030 When pending becomes 0 and no group is accepted, SHALL return to IDLE.
REQ-031 On simultaneous final issue and new acceptance, SHALL load the new group directly and stay in ISSUE with no bubble.
REQ-032 SHALL increment stall_cnt on each ISSUE cycle with mem_ready=0 and k existing, saturating at 2^CNT_W-1 with no wrap.
REQ-033 SHALL drive busy = (state == ISSUE).
REQ-034 SHALL output issue=0 and mem_issue=0 in IDLE.

Reset
REQ-035 rst_n low SHALL immediately force state=IDLE, pending=0, stored opcodes=0, stall_cnt=0, issue=0, mem_issue=0, mem_slot=0, busy=0, grp_ready=1.
REQ-036 Reset mid-group SHALL discard all pending slots; no issue strobe SHALL follow until a new group is accepted.

Verification
REQ-037 Scenario: ops {ADD,ADD,ADD,ADD}, vld=1111, mem_ready=1 -> issue=1111 in cycle N+1, busy=0 in N+2.
REQ-038 Scenario: ops {LD,ADD,ST,ADD}, vld=1111, mem_ready=1 -> N+1: issue=0011, mem_slot=0; N+2: issue=1100, mem_slot=2.
REQ-039 Scenario: ops {ADD,LD,ADD,ADD}, mem_ready=0 for 3 cycles, then 1 -> issue=0001 once, then 0000 for 2 cycles, then issue=1110 with mem_slot=1; stall_cnt=3.
REQ-040 Scenario: vld=0101, ops {ST,LD,LD,ADD}, mem_ready=1 -> N+1: issue=0001; N+2: issue=0100, mem_slot=2.
REQ-041 Scenario: back-to-back groups, grp_valid held high, no memory ops -> grp_ready=1 every cycle and issue=1111 every cycle with no bubble.
REQ-042 Scenario: rst_n pulsed low during N+1 of REQ-038 -> no issue thereafter, busy=0, stall_cnt=0; and with mem_ready=0 held for 300 cycles, stall_cnt saturates at 255.

Source files
------------

// File: rtl/mem_issue_sequencer.sv
// mem_issue_sequencer: issues a 4-slot instruction group in order, letting at
// most one load/store per cycle reach the single memory port (ALU4).
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   grp_valid / grp_ready group offer / accept handshake
//   op1..op4, vld         slot opcodes and per-slot valid (bit i-1 = slot i)
//   mem_ready             memory port can take an op this cycle
//   issue                 per-slot one-cycle issue strobe
//   mem_issue, mem_slot   memory op issued this cycle and its slot index
//   busy                  group still has pending slots
//   stall_cnt             saturating count of memory-stall cycles
module mem_issue_sequencer #(
    parameter logic [3:0] LOAD_OP  = 4'b0010,
    parameter logic [3:0] STORE_OP = 4'b0100,
    parameter int         CNT_W    = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             grp_valid,
    output logic             grp_ready,
    input  logic [3:0]       op1,
    input  logic [3:0]       op2,
    input  logic [3:0]       op3,
    input  logic [3:0]       op4,
    input  logic [3:0]       vld,
    input  logic             mem_ready,
    output logic [3:0]       issue,
    output logic             mem_issue,
    output logic [1:0]       mem_slot,
    output logic             busy,
    output logic [CNT_W-1:0] stall_cnt
);

    typedef enum logic { IDLE = 1'b0, ISSUE = 1'b1 } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    state_t      state;
    logic [15:0] ops;
    logic [3:0]  pending;

    logic [3:0]  is_mem;
    logic [3:0]  pend_mem;
    logic [1:0]  k;
    logic [1:0]  m;
    logic        k_ok;
    logic        m_ok;
    logic [3:0]  below_k;
    logic [3:0]  below_m;
    logic [3:0]  left;
    logic        accept;
    logic        stall;

    // Find the oldest (k) and second-oldest (m) pending memory slots.
    always_comb begin
        k    = 2'd0;
        m    = 2'd0;
        k_ok = 1'b0;
        m_ok = 1'b0;
        for (int i = 0; i < 4; i++) begin
            is_mem[i]   = (ops[4*i +: 4] == LOAD_OP) ||
                          (ops[4*i +: 4] == STORE_OP);
            pend_mem[i] = pending[i] && is_mem[i];
        end
        for (int i = 0; i < 4; i++) begin
            if (pend_mem[i]) begin
                if (!k_ok) begin
                    k    = i[1:0];
                    k_ok = 1'b1;
                end else if (!m_ok) begin
                    m    = i[1:0];
                    m_ok = 1'b1;
                end
            end
        end
    end

    assign below_k = (4'b0001 << k) - 4'b0001;
    assign below_m = (4'b0001 << m) - 4'b0001;

    // With the port free, slot k goes out together with everything before m;
    // with the port stalled, only slots older than k may proceed.
    always_comb begin
        issue     = 4'b0000;
        mem_issue = 1'b0;
        mem_slot  = 2'd0;
        if (state == ISSUE) begin
            if (!k_ok) begin
                issue = pending;
            end else if (mem_ready) begin
                issue     = m_ok ? (pending & below_m) : pending;
                mem_issue = 1'b1;
                mem_slot  = k;
            end else begin
                issue = pending & below_k;
            end
        end
    end

    assign left      = pending & ~issue;
    assign grp_ready = (state == IDLE) || (left == 4'b0000);
    assign accept    = grp_valid && grp_ready;
    assign busy      = (state == ISSUE);
    assign stall     = (state == ISSUE) && !mem_ready && k_ok;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            ops       <= 16'h0000;
            pending   <= 4'b0000;
            stall_cnt <= '0;
        end else begin
            if (accept) begin
                ops     <= {op4, op3, op2, op1};
                pending <= vld;
                state   <= (vld != 4'b0000) ? ISSUE : IDLE;
            end else if (state == ISSUE) begin
                pending <= left;
                if (left == 4'b0000) begin
                    state <= IDLE;
                end
            end
            if (stall && stall_cnt != CNT_MAX) begin
                stall_cnt <= stall_cnt + 1'b1;
            end
        end
    end

endmodule
